// File: rtl/cpu_pkg.sv
// Shared core constants and the fetch-stage state encoding.
// Imported by the fetch front end and its IF/ID register.
package cpu_pkg;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_frontend_ifid_reg.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush.
// Flush takes priority over stall.
module ifid_reg #(
    parameter int          ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic              valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc_q    <= pc_i;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= valid_i;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_frontend.sv
// Fetch stage: PC, imem req/ack handshake, squash of wrong-path fetches
// and the hold buffer that parks a fetched word while ID is stalled.
module if_fetch_frontend #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    parameter logic [31:0]       NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pc_write_i,
    input  logic              ifid_stall_i,
    input  logic              ifid_flush_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [31:0]       ifid_inst_o,
    output logic              ifid_valid_o,
    output logic              fetch_busy_o
);

    import cpu_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]       hold_inst_q, hold_inst_d;
    logic              hold_vld_q, hold_vld_d;
    logic              squash_q, squash_d;
    logic              req_q, req_d;
    logic              busy_q;

    logic              issue;
    logic              ack;
    logic              new_req;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt;

    logic [ADDR_W-1:0] ld_pc;
    logic [31:0]       ld_inst;
    logic              ld_valid;

    assign issue  = start_i & pc_write_i;
    assign ack    = req_q & imem_ack_i;
    assign pc_inc = pc_q + ADDR_W'(4);
    assign tgt    = branch_target_i & ~ADDR_W'(3);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        req_d       = req_q;
        new_req     = 1'b0;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        hold_vld_d  = hold_vld_q;
        ld_pc       = pc_q;
        ld_inst     = NOP_INST;
        ld_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ifid_flush_i) pc_d = tgt;
                if (start_i) begin
                    state_d = FETCH;
                    req_d   = pc_write_i;
                    new_req = pc_write_i;
                end
            end
            FETCH: begin
                if (req_q && !ack) begin
                    // request still in flight: it must finish at its own address
                    if (ifid_flush_i) begin
                        squash_d = 1'b1;
                        pc_d     = tgt;
                    end
                end else begin
                    if (ack && !squash_q && !ifid_flush_i) begin
                        if (!ifid_stall_i) begin
                            ld_inst  = imem_data_i;
                            ld_valid = 1'b1;
                            if (pc_write_i) pc_d = pc_inc;
                            req_d = issue;
                        end else begin
                            hold_pc_d   = pc_q;
                            hold_inst_d = imem_data_i;
                            hold_vld_d  = 1'b1;
                            state_d     = HOLD;
                            req_d       = 1'b0;
                        end
                    end else begin
                        if (ifid_flush_i) pc_d = tgt;
                        squash_d = 1'b0;
                        req_d    = issue;
                    end
                    new_req = req_d;
                    if (state_d == FETCH && !req_d && !start_i) state_d = IDLE;
                end
            end
            HOLD: begin
                ld_pc    = hold_pc_q;
                ld_inst  = hold_inst_q;
                ld_valid = hold_vld_q;
                if (ifid_flush_i || !ifid_stall_i) begin
                    pc_d       = ifid_flush_i ? tgt : pc_inc;
                    hold_vld_d = 1'b0;
                    state_d    = FETCH;
                    req_d      = issue;
                    new_req    = issue;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        addr_d = new_req ? pc_d : addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            hold_pc_q   <= '0;
            hold_inst_q <= NOP_INST;
            hold_vld_q  <= 1'b0;
            squash_q    <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_vld_q  <= hold_vld_d;
            squash_q    <= squash_d;
            req_q       <= req_d;
            busy_q      <= (state_d == FETCH) & req_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign fetch_busy_o = busy_q;

    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP_INST)
    ) u_ifid_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (ifid_stall_i),
        .flush_i (ifid_flush_i),
        .pc_i    (ld_pc),
        .inst_i  (ld_inst),
        .valid_i (ld_valid),
        .pc_o    (ifid_pc_o),
        .inst_o  (ifid_inst_o),
        .valid_o (ifid_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_frontend.sv
// Bench for if_fetch_frontend: variable-latency memory, directed
// scenarios, then random hazard controls against a transaction model.
module tb_if_fetch_frontend;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, start, pcw, stall, flush;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] mdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_vld;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model state
    bit          mem_act;
    int          mem_left;
    logic [31:0] mem_addr;
    int          lat;

    // reference model state
    bit          m_run, m_park, m_wait, m_wrong;
    logic [31:0] m_pc, m_pend, m_ppc, m_pinst;
    logic [31:0] e_pc, e_inst;
    bit          e_vld;

    always #5 clk = ~clk;

    if_fetch_frontend dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .pc_write_i      (pcw),
        .ifid_stall_i    (stall),
        .ifid_flush_i    (flush),
        .branch_target_i (tgt),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (ack),
        .imem_data_i     (mdata),
        .ifid_pc_o       (if_pc),
        .ifid_inst_o     (if_inst),
        .ifid_valid_o    (if_vld),
        .fetch_busy_o    (busy)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic model_reset();
        m_run = 0; m_park = 0; m_wait = 0; m_wrong = 0;
        m_pc = 0; m_pend = 0; m_ppc = 0; m_pinst = NOP;
        e_pc = 0; e_inst = NOP; e_vld = 0;
    endtask

    // One cycle of fetch behaviour, written as transactions:
    // a word is delivered, parked, discarded, or a bubble goes out.
    task automatic model_step();
        bit          issue, got;
        logic [31:0] tg;
        if (rst) begin
            model_reset();
            return;
        end
        tg    = {tgt[31:2], 2'b00};
        issue = start && pcw;
        got   = m_run && !m_park && m_wait && ack && !m_wrong;

        if (flush) begin
            e_pc = m_pc; e_inst = NOP; e_vld = 0;
        end else if (!stall) begin
            if (got) begin
                e_pc = m_pc; e_inst = mdata; e_vld = 1;
            end else if (m_park) begin
                e_pc = m_ppc; e_inst = m_pinst; e_vld = 1;
            end else begin
                e_pc = m_pc; e_inst = NOP; e_vld = 0;
            end
        end

        if (m_park) begin
            if (flush || !stall) begin
                m_pc   = flush ? tg : m_pc + 32'd4;
                m_park = 0;
                m_wait = issue;
                m_pend = m_pc;
            end
        end else if (!m_run) begin
            if (flush) m_pc = tg;
            if (start) begin
                m_run  = 1;
                m_wait = pcw;
                m_pend = m_pc;
            end
        end else if (m_wait && !ack) begin
            if (flush) begin
                m_wrong = 1;
                m_pc    = tg;
            end
        end else begin
            if (got && !flush) begin
                if (stall) begin
                    m_park  = 1;
                    m_ppc   = m_pc;
                    m_pinst = mdata;
                    m_wait  = 0;
                end else begin
                    if (pcw) m_pc = m_pc + 32'd4;
                    m_wait = issue;
                end
            end else begin
                if (flush) m_pc = tg;
                m_wrong = 0;
                m_wait  = issue;
            end
            m_pend = m_pc;
            if (!m_wait && !m_park && !start) m_run = 0;
        end
    endtask

    task automatic tick();
        check("req", imem_req, m_wait);
        if (m_wait) check("addr", imem_addr, m_pend);
        check("busy", busy, m_run && m_wait);
        check("if_pc", if_pc, e_pc);
        check("if_inst", if_inst, e_inst);
        check("if_vld", if_vld, e_vld);

        ack   = 1'b0;
        mdata = $urandom;
        if (rst) begin
            mem_act = 0;
        end else if (mem_act) begin
            mem_left--;
            if (mem_left == 0) begin
                ack     = 1'b1;
                mdata   = mem_word(mem_addr);
                mem_act = 0;
            end
        end else if (imem_req) begin
            mem_act  = 1;
            mem_left = lat;
            mem_addr = imem_addr;
        end

        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; start = 0; pcw = 1; stall = 0; flush = 0; tgt = 0;
        ack = 0; mdata = 0; lat = 1; mem_act = 0; mem_left = 0; mem_addr = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_inst", if_inst, NOP);
        check("rst_vld", if_vld, 0);
        check("rst_pc", if_pc, 0);
        check("rst_busy", busy, 0);

        // zero-wait memory: one instruction every two cycles
        rst = 0; start = 1; pcw = 1;
        tick();
        check("s1_req", imem_req, 1);
        check("s1_addr0", imem_addr, 32'h0);
        tick(); tick();
        check("s1_addr4", imem_addr, 32'h4);
        check("s1_pc0", if_pc, 32'h0);
        check("s1_vld", if_vld, 1);
        tick();
        check("s1_bubble", if_vld, 0);
        tick();
        check("s1_addr8", imem_addr, 32'h8);
        check("s1_pc4", if_pc, 32'h4);

        // stall with pc_write low on the ack of 0x8
        stall = 1;
        tick();
        pcw = 0;
        tick();
        check("s3_noreq", imem_req, 0);
        check("s3_hold_pc", if_pc, 32'h4);
        check("s3_hold_vld", if_vld, 1);
        tick();
        stall = 0; pcw = 1; lat = 3;
        tick();
        check("s3_pc8", if_pc, 32'h8);
        check("s3_vld8", if_vld, 1);
        check("s3_addrC", imem_addr, 32'hC);

        // three-cycle memory latency
        for (int i = 0; i < 4; i++) begin
            check("s2_addr", imem_addr, 32'hC);
            check("s2_busy", busy, 1);
            if (i > 0) check("s2_bubble", if_vld, 0);
            tick();
        end
        check("s2_pcC", if_pc, 32'hC);
        check("s2_vldC", if_vld, 1);
        check("s2_addr10", imem_addr, 32'h10);

        // flush while 0x10 is pending
        flush = 1; tgt = 32'h40;
        tick();
        flush = 0; lat = 1;
        check("s4_addr_keep", imem_addr, 32'h10);
        check("s4_vld0", if_vld, 0);
        tick(); tick(); tick();
        check("s4_addr40", imem_addr, 32'h40);
        check("s4_discard", if_vld, 0);
        tick(); tick();
        check("s4_pc40", if_pc, 32'h40);
        check("s4_vld40", if_vld, 1);

        // flush coincident with the ack of 0x44
        tick();
        flush = 1; tgt = 32'h83;
        tick();
        flush = 0;
        check("s5_addr80", imem_addr, 32'h80);
        check("s5_drop", if_vld, 0);
        tick(); tick();
        check("s5_pc80", if_pc, 32'h80);
        check("s5_vld80", if_vld, 1);

        // reset in the middle of a fetch
        rst = 1;
        tick();
        rst = 0;
        check("s6_req", imem_req, 0);
        check("s6_inst", if_inst, NOP);
        check("s6_vld", if_vld, 0);
        tick();
        check("s6_restart", imem_addr, 32'h0);
        check("s6_req1", imem_req, 1);

        // random hazard traffic, including targets near the top of memory
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 19) != 0);
            pcw   = ($urandom_range(0, 4) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 11) == 0);
            tgt   = ($urandom_range(0, 5) == 0) ?
                    (32'hFFFF_FFF8 | ($urandom & 32'h3)) : $urandom;
            lat   = $urandom_range(1, 4);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
